// File: rtl/i2s_capture_scheduler_if.sv
// Bundle between the I2S capture scheduler, the bit-serial receiver and
// the downstream sample consumer.
interface i2s_capture_scheduler_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
);
    logic                  sck;
    logic                  ws;
    logic [DATA_WIDTH-1:0] rx_data_left;
    logic [DATA_WIDTH-1:0] rx_data_right;
    logic [DATA_WIDTH-1:0] sample_left;
    logic [DATA_WIDTH-1:0] sample_right;
    logic                  sample_valid;
    logic                  sample_ready;
    logic                  overflow;
    logic                  clear_overflow;
    logic [CNT_WIDTH-1:0]  frame_count;

    modport master (
        output sck, ws,
        output sample_left, sample_right, sample_valid,
        output overflow, frame_count,
        input  rx_data_left, rx_data_right,
        input  sample_ready, clear_overflow
    );

    modport slave (
        input  sck, ws,
        input  sample_left, sample_right, sample_valid,
        input  overflow, frame_count,
        output rx_data_left, rx_data_right,
        output sample_ready, clear_overflow
    );
endinterface

// File: rtl/i2s_capture_scheduler.sv
// Master-mode I2S clock generator and stereo capture sequencer: drives sck/ws,
// snapshots the receiver's words, and hands pairs downstream via valid/ready.
module i2s_capture_scheduler #(
    parameter int unsigned DATA_WIDTH       = 32,
    parameter int unsigned SCK_DIV          = 4,
    parameter int unsigned BITS_PER_CHANNEL = 32,
    parameter int unsigned CAPTURE_DELAY    = 2,
    parameter int unsigned CNT_WIDTH        = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    i2s_capture_scheduler_if.master bus
);
    localparam int unsigned DIV_W = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
    localparam int unsigned BIT_W = (BITS_PER_CHANNEL > 1) ? $clog2(BITS_PER_CHANNEL) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BITS_PER_CHANNEL - 1);
    localparam logic [BIT_W-1:0] CAP_LAST = BIT_W'(CAPTURE_DELAY - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOP
    } state_t;

    state_t state, state_next;

    logic [DIV_W-1:0]      div_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic [BIT_W-1:0]      cap_cnt;
    logic                  cap_armed;
    logic                  sck_q;
    logic                  ws_q;
    logic                  primed;
    logic [DATA_WIDTH-1:0] hold_left;
    logic [DATA_WIDTH-1:0] sample_left_q;
    logic [DATA_WIDTH-1:0] sample_right_q;
    logic                  sample_valid_q;
    logic                  overflow_q;
    logic [CNT_WIDTH-1:0]  frame_cnt_q;

    logic running;
    logic tick;
    logic sck_fall;
    logic ws_flip;
    logic cap_fire;
    logic cap_left;
    logic pair_done;
    logic deliver;
    logic accept;
    logic transfer;
    logic clocks_clear;

    always_comb begin
        running   = (state != IDLE);
        tick      = running && (div_cnt == DIV_LAST);
        sck_fall  = tick && sck_q;
        ws_flip   = sck_fall && (bit_cnt == BIT_LAST);
        cap_fire  = sck_fall && cap_armed && (cap_cnt == CAP_LAST);
        // ws is still the pre-edge value here: high means the left word just finished
        cap_left  = cap_fire && ws_q;
        pair_done = cap_fire && !ws_q;
        deliver   = pair_done && primed;
        accept    = !sample_valid_q || bus.sample_ready;
        transfer  = sample_valid_q && bus.sample_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (enable) begin
                    state_next = RUN;
                end else if (pair_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign clocks_clear = (state == IDLE) || (state_next == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt   <= '0;
            bit_cnt   <= '0;
            cap_cnt   <= '0;
            cap_armed <= 1'b0;
            sck_q     <= 1'b0;
            ws_q      <= 1'b0;
        end else if (clocks_clear) begin
            div_cnt   <= '0;
            bit_cnt   <= '0;
            cap_cnt   <= '0;
            cap_armed <= 1'b0;
            sck_q     <= 1'b0;
            ws_q      <= 1'b0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
            if (tick) begin
                sck_q <= ~sck_q;
            end
            if (sck_fall) begin
                if (bit_cnt == BIT_LAST) begin
                    bit_cnt <= '0;
                    ws_q    <= ~ws_q;
                end else begin
                    bit_cnt <= bit_cnt + BIT_W'(1);
                end
            end
            // Capture counter only runs once a ws edge has been seen in this run
            if (ws_flip) begin
                cap_armed <= 1'b1;
                cap_cnt   <= '0;
            end else if (cap_fire) begin
                cap_armed <= 1'b0;
            end else if (sck_fall && cap_armed) begin
                cap_cnt <= cap_cnt + BIT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            primed         <= 1'b0;
            hold_left      <= '0;
            sample_left_q  <= '0;
            sample_right_q <= '0;
            sample_valid_q <= 1'b0;
            overflow_q     <= 1'b0;
            frame_cnt_q    <= '0;
        end else begin
            if (state == IDLE) begin
                primed <= 1'b0;
            end else if (pair_done) begin
                primed <= 1'b1;
            end
            if (cap_left) begin
                hold_left <= bus.rx_data_left;
            end
            if (deliver) begin
                frame_cnt_q <= frame_cnt_q + CNT_WIDTH'(1);
            end
            if (deliver && accept) begin
                sample_left_q  <= hold_left;
                sample_right_q <= bus.rx_data_right;
                sample_valid_q <= 1'b1;
            end else if (transfer) begin
                sample_valid_q <= 1'b0;
            end
            if (deliver && !accept) begin
                overflow_q <= 1'b1;
            end else if (bus.clear_overflow) begin
                overflow_q <= 1'b0;
            end
        end
    end

    assign bus.sck          = sck_q;
    assign bus.ws           = ws_q;
    assign bus.sample_left  = sample_left_q;
    assign bus.sample_right = sample_right_q;
    assign bus.sample_valid = sample_valid_q;
    assign bus.overflow     = overflow_q;
    assign bus.frame_count  = frame_cnt_q;
endmodule

// File: tb/tb_i2s_capture_scheduler.sv
// Directed bench for i2s_capture_scheduler: a timeline-based model predicts
// sck/ws and the sample stream each cycle, plus hand-computed spot checks.
module tb_i2s_capture_scheduler;
    localparam int unsigned DW      = 32;
    localparam int unsigned CW      = 16;
    localparam int unsigned SCK_DIV = 4;
    localparam int unsigned BPC     = 32;
    localparam int unsigned CD      = 2;

    localparam int unsigned FALL_PERIOD = 2 * SCK_DIV;
    localparam int unsigned WS_HALF     = BPC * FALL_PERIOD;
    localparam int unsigned FRAME       = 2 * WS_HALF;
    localparam int unsigned LCAP        = WS_HALF + CD * FALL_PERIOD;
    localparam int unsigned RCAP        = FRAME + CD * FALL_PERIOD;

    logic clk    = 1'b0;
    logic rst_n  = 1'b1;
    logic enable = 1'b0;
    logic started = 1'b0;

    i2s_capture_scheduler_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

    i2s_capture_scheduler #(
        .DATA_WIDTH(DW),
        .SCK_DIV(SCK_DIV),
        .BITS_PER_CHANNEL(BPC),
        .CAPTURE_DELAY(CD),
        .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: run timeline measured in clk edges since leaving idle
    typedef enum {M_IDLE, M_RUN, M_STOP} mphase_t;
    mphase_t         m_phase = M_IDLE;
    int unsigned     m_k     = 0;
    int unsigned     m_pairs = 0;
    logic [DW-1:0]   m_hold  = '0;
    logic [DW-1:0]   m_sl    = '0;
    logic [DW-1:0]   m_sr    = '0;
    logic            m_valid = 1'b0;
    logic            m_ovf   = 1'b0;
    logic [CW-1:0]   m_fc    = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = M_IDLE;
            m_k     = 0;
            m_pairs = 0;
            m_hold  = '0;
            m_sl    = '0;
            m_sr    = '0;
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_fc    = '0;
        end else begin
            logic lc, rc, load, drop;
            lc   = 1'b0;
            rc   = 1'b0;
            load = 1'b0;
            drop = 1'b0;
            if (m_phase == M_IDLE) begin
                if (enable) begin
                    m_phase = M_RUN;
                    m_k     = 0;
                    m_pairs = 0;
                end
            end else begin
                m_k++;
                lc = (m_k >= LCAP) && ((m_k - LCAP) % FRAME == 0);
                rc = (m_k >= RCAP) && ((m_k - RCAP) % FRAME == 0);
                if (lc) m_hold = bus.rx_data_left;
                if (rc && m_pairs > 0) begin
                    m_fc = m_fc + 1'b1;
                    if (!m_valid || bus.sample_ready) load = 1'b1;
                    else drop = 1'b1;
                end
                if (rc) m_pairs++;
                if (m_phase == M_RUN && !enable) m_phase = M_STOP;
                else if (m_phase == M_STOP && enable) m_phase = M_RUN;
                else if (m_phase == M_STOP && rc) m_phase = M_IDLE;
            end
            if (load) begin
                m_sl    = m_hold;
                m_sr    = bus.rx_data_right;
                m_valid = 1'b1;
            end else if (m_valid && bus.sample_ready) begin
                m_valid = 1'b0;
            end
            if (drop) m_ovf = 1'b1;
            else if (bus.clear_overflow) m_ovf = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            logic e_sck, e_ws;
            e_sck = (m_phase != M_IDLE) && (((m_k / SCK_DIV) % 2) == 1);
            e_ws  = (m_phase != M_IDLE) && (((m_k / WS_HALF) % 2) == 1);
            check("sck", 64'(bus.sck), 64'(e_sck));
            check("ws", 64'(bus.ws), 64'(e_ws));
            check("sample_valid", 64'(bus.sample_valid), 64'(m_valid));
            check("overflow", 64'(bus.overflow), 64'(m_ovf));
            check("frame_count", 64'(bus.frame_count), 64'(m_fc));
            if (m_valid) begin
                check("sample_left", 64'(bus.sample_left), 64'(m_sl));
                check("sample_right", 64'(bus.sample_right), 64'(m_sr));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic set_rx(input logic [DW-1:0] l, input logic [DW-1:0] r);
        bus.rx_data_left  = l;
        bus.rx_data_right = r;
    endtask

    initial begin
        bus.sample_ready   = 1'b0;
        bus.clear_overflow = 1'b0;
        set_rx('0, '0);
        #1 rst_n = 1'b0;
        started = 1'b1;
        step(3);
        check("rst_sck", 64'(bus.sck), 64'd0);
        check("rst_valid", 64'(bus.sample_valid), 64'd0);
        check("rst_fc", 64'(bus.frame_count), 64'd0);
        rst_n = 1'b1;
        set_rx(32'hA5A5_0001, 32'h5A5A_0002);
        bus.sample_ready = 1'b1;
        step(5);
        check("idle_sck", 64'(bus.sck), 64'd0);
        check("idle_ws", 64'(bus.ws), 64'd0);

        // Run 1: timeline indices are edges after the enabling edge E0
        enable = 1'b1;
        step(4);                         // E3
        check("sck_before_rise", 64'(bus.sck), 64'd0);
        step(1);                         // E4
        check("sck_first_rise", 64'(bus.sck), 64'd1);
        step(251);                       // E255
        check("ws_before_toggle", 64'(bus.ws), 64'd0);
        step(1);                         // E256
        check("ws_toggle", 64'(bus.ws), 64'd1);
        step(272);                       // E528
        check("discard_valid", 64'(bus.sample_valid), 64'd0);
        check("discard_fc", 64'(bus.frame_count), 64'd0);
        step(512);                       // E1040
        check("pair1_valid", 64'(bus.sample_valid), 64'd1);
        check("pair1_left", 64'(bus.sample_left), 64'hA5A5_0001);
        check("pair1_right", 64'(bus.sample_right), 64'h5A5A_0002);
        check("pair1_fc", 64'(bus.frame_count), 64'd1);
        step(1);                         // E1041
        check("pair1_taken", 64'(bus.sample_valid), 64'd0);

        bus.sample_ready = 1'b0;
        set_rx(32'h1111_0003, 32'h2222_0004);
        step(511);                       // E1552
        check("pair2_left", 64'(bus.sample_left), 64'h1111_0003);
        check("pair2_fc", 64'(bus.frame_count), 64'd2);
        set_rx(32'h3333_0005, 32'h4444_0006);
        step(512);                       // E2064
        check("drop_overflow", 64'(bus.overflow), 64'd1);
        check("drop_held_left", 64'(bus.sample_left), 64'h1111_0003);
        check("drop_held_right", 64'(bus.sample_right), 64'h2222_0004);
        check("drop_fc", 64'(bus.frame_count), 64'd3);
        step(1);                         // E2065
        bus.clear_overflow = 1'b1;
        step(1);                         // E2066
        check("clear_overflow", 64'(bus.overflow), 64'd0);
        bus.clear_overflow = 1'b0;
        set_rx(32'h5555_0007, 32'h6666_0008);
        step(509);                       // E2575
        bus.sample_ready = 1'b1;
        step(1);                         // E2576
        check("swap_valid", 64'(bus.sample_valid), 64'd1);
        check("swap_left", 64'(bus.sample_left), 64'h5555_0007);
        check("swap_right", 64'(bus.sample_right), 64'h6666_0008);
        check("swap_overflow", 64'(bus.overflow), 64'd0);
        check("swap_fc", 64'(bus.frame_count), 64'd4);
        step(24);                        // E2600, mid left half
        enable = 1'b0;
        set_rx(32'h7777_0009, 32'h8888_000A);
        step(487);                       // E3087
        check("stop_sck_running", 64'(bus.sck), 64'd1);
        step(1);                         // E3088
        check("stop_final_valid", 64'(bus.sample_valid), 64'd1);
        check("stop_final_left", 64'(bus.sample_left), 64'h7777_0009);
        check("stop_final_fc", 64'(bus.frame_count), 64'd5);
        step(12);                        // E3100
        check("stop_idle_sck", 64'(bus.sck), 64'd0);
        check("stop_idle_ws", 64'(bus.ws), 64'd0);

        // Run 2: re-enable during STOP must not disturb the clocks
        set_rx(32'h9999_0011, 32'hAAAA_0012);
        enable = 1'b1;
        step(101);                       // E100
        enable = 1'b0;
        step(50);                        // E150
        check("restop_sck", 64'(bus.sck), 64'd1);
        step(50);                        // E200
        enable = 1'b1;
        step(840);                       // E1040
        check("run2_valid", 64'(bus.sample_valid), 64'd1);
        check("run2_left", 64'(bus.sample_left), 64'h9999_0011);
        check("run2_fc", 64'(bus.frame_count), 64'd6);
        bus.sample_ready = 1'b0;
        step(100);
        check("run2_hold", 64'(bus.sample_valid), 64'd1);

        // Asynchronous reset with a pair pending
        rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(bus.sample_valid), 64'd0);
        check("arst_left", 64'(bus.sample_left), 64'd0);
        check("arst_fc", 64'(bus.frame_count), 64'd0);
        check("arst_sck", 64'(bus.sck), 64'd0);
        step(3);
        rst_n = 1'b1;
        bus.sample_ready = 1'b1;
        step(529);                       // E528
        check("rerun_discard_fc", 64'(bus.frame_count), 64'd0);
        check("rerun_discard_valid", 64'(bus.sample_valid), 64'd0);
        step(512);                       // E1040
        check("rerun_fc", 64'(bus.frame_count), 64'd1);
        check("rerun_left", 64'(bus.sample_left), 64'h9999_0011);
        step(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
